// File: rtl/lc3_decode.sv
// LC-3 decode stage: registers the fetched instruction and next-PC, and presents
// decoded ALU, register, immediate and memory controls one cycle later.
module lc3_decode #(
  parameter int         DATA_W   = 16,
  parameter logic [2:0] LINK_REG = 3'd7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_decode,
  input  logic              flush,
  input  logic [DATA_W-1:0] instr_in,
  input  logic [DATA_W-1:0] npc_in,
  output logic [DATA_W-1:0] ir,
  output logic [DATA_W-1:0] npc_out,
  output logic              decode_valid,
  output logic [1:0]        alu_control,
  output logic              alu_op,
  output logic              imm_mode,
  output logic [DATA_W-1:0] imm5_sext,
  output logic [DATA_W-1:0] offset_sext,
  output logic [2:0]        sr1,
  output logic [2:0]        sr2,
  output logic [2:0]        dr,
  output logic              reg_we,
  output logic [1:0]        w_control,
  output logic [1:0]        mem_control,
  output logic              mem_indirect,
  output logic              illegal
);

  localparam logic [3:0] OP_BR   = 4'b0000;
  localparam logic [3:0] OP_ADD  = 4'b0001;
  localparam logic [3:0] OP_LD   = 4'b0010;
  localparam logic [3:0] OP_ST   = 4'b0011;
  localparam logic [3:0] OP_JSR  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0101;
  localparam logic [3:0] OP_LDR  = 4'b0110;
  localparam logic [3:0] OP_STR  = 4'b0111;
  localparam logic [3:0] OP_NOT  = 4'b1001;
  localparam logic [3:0] OP_LDI  = 4'b1010;
  localparam logic [3:0] OP_STI  = 4'b1011;
  localparam logic [3:0] OP_JMP  = 4'b1100;
  localparam logic [3:0] OP_LEA  = 4'b1110;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  logic [3:0]        opcode;
  logic [DATA_W-1:0] off6, off9, off11, trapvect;
  logic [1:0]        alu_control_next, w_control_next, mem_control_next;
  logic              alu_op_next, imm_mode_next, reg_we_next, mem_indirect_next, illegal_next;
  logic [DATA_W-1:0] imm5_sext_next, offset_sext_next;
  logic [2:0]        sr2_next, dr_next;

  assign opcode   = instr_in[15:12];
  assign off6     = {{(DATA_W-6){instr_in[5]}}, instr_in[5:0]};
  assign off9     = {{(DATA_W-9){instr_in[8]}}, instr_in[8:0]};
  assign off11    = {{(DATA_W-11){instr_in[10]}}, instr_in[10:0]};
  assign trapvect = {{(DATA_W-8){1'b0}}, instr_in[7:0]};

  always_comb begin
    alu_control_next  = 2'd0;
    alu_op_next       = 1'b0;
    imm_mode_next     = 1'b0;
    imm5_sext_next    = {{(DATA_W-5){instr_in[4]}}, instr_in[4:0]};
    offset_sext_next  = '0;
    sr2_next          = 3'd0;
    dr_next           = 3'd0;
    reg_we_next       = 1'b0;
    w_control_next    = 2'd0;
    mem_control_next  = 2'd0;
    mem_indirect_next = 1'b0;
    illegal_next      = 1'b0;
    case (opcode)
      OP_ADD, OP_AND: begin
        alu_control_next = (opcode == OP_AND) ? 2'd1 : 2'd0;
        alu_op_next      = 1'b1;
        imm_mode_next    = instr_in[5];
        sr2_next         = instr_in[2:0];
        dr_next          = instr_in[11:9];
        reg_we_next      = 1'b1;
      end
      OP_NOT: begin
        alu_control_next = 2'd2;
        alu_op_next      = 1'b1;
        dr_next          = instr_in[11:9];
        reg_we_next      = 1'b1;
      end
      OP_LD, OP_LDI, OP_LDR: begin
        offset_sext_next  = (opcode == OP_LDR) ? off6 : off9;
        mem_control_next  = 2'd1;
        mem_indirect_next = (opcode == OP_LDI);
        dr_next           = instr_in[11:9];
        reg_we_next       = 1'b1;
        w_control_next    = 2'd1;
      end
      OP_ST, OP_STI, OP_STR: begin
        offset_sext_next  = (opcode == OP_STR) ? off6 : off9;
        sr2_next          = instr_in[11:9];
        mem_control_next  = 2'd2;
        mem_indirect_next = (opcode == OP_STI);
      end
      OP_LEA: begin
        offset_sext_next = off9;
        dr_next          = instr_in[11:9];
        reg_we_next      = 1'b1;
        w_control_next   = 2'd2;
      end
      OP_BR:  offset_sext_next = off9;
      OP_JMP: offset_sext_next = '0;
      OP_JSR: begin
        // JSRR (ir[11]=0) takes its target from the base register, so no offset
        offset_sext_next = instr_in[11] ? off11 : '0;
        dr_next          = LINK_REG;
        reg_we_next      = 1'b1;
        w_control_next   = 2'd2;
      end
      OP_TRAP: begin
        offset_sext_next = trapvect;
        dr_next          = LINK_REG;
        reg_we_next      = 1'b1;
        w_control_next   = 2'd2;
      end
      default: illegal_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir           <= '0;
      npc_out      <= '0;
      decode_valid <= 1'b0;
      alu_control  <= 2'd0;
      alu_op       <= 1'b0;
      imm_mode     <= 1'b0;
      imm5_sext    <= '0;
      offset_sext  <= '0;
      sr1          <= 3'd0;
      sr2          <= 3'd0;
      dr           <= 3'd0;
      reg_we       <= 1'b0;
      w_control    <= 2'd0;
      mem_control  <= 2'd0;
      mem_indirect <= 1'b0;
      illegal      <= 1'b0;
    end else if (flush) begin
      // Kill only the side-effecting controls; datapath fields stay put
      decode_valid <= 1'b0;
      reg_we       <= 1'b0;
      mem_control  <= 2'd0;
      mem_indirect <= 1'b0;
      illegal      <= 1'b0;
    end else if (enable_decode) begin
      ir           <= instr_in;
      npc_out      <= npc_in;
      decode_valid <= 1'b1;
      alu_control  <= alu_control_next;
      alu_op       <= alu_op_next;
      imm_mode     <= imm_mode_next;
      imm5_sext    <= imm5_sext_next;
      offset_sext  <= offset_sext_next;
      sr1          <= instr_in[8:6];
      sr2          <= sr2_next;
      dr           <= dr_next;
      reg_we       <= reg_we_next;
      w_control    <= w_control_next;
      mem_control  <= mem_control_next;
      mem_indirect <= mem_indirect_next;
      illegal      <= illegal_next;
    end
  end

endmodule

// File: tb/tb_lc3_decode.sv
// Testbench for lc3_decode: directed ISA cases followed by random instruction
// streams, all checked against an instruction-level reference model.
module tb_lc3_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable_decode = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] instr_in = 16'h0000;
  logic [15:0] npc_in = 16'h0000;
  logic [15:0] ir, npc_out, imm5_sext, offset_sext;
  logic        decode_valid, alu_op, imm_mode, reg_we, mem_indirect, illegal;
  logic [1:0]  alu_control, w_control, mem_control;
  logic [2:0]  sr1, sr2, dr;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [15:0] ir, npc, imm5, off;
    logic        valid, alu_op, imm_mode, reg_we, mem_ind, illegal;
    logic [1:0]  alu_ctl, w_ctl, mem_ctl;
    logic [2:0]  sr1, sr2, dr;
  } dec_t;

  dec_t exp_s = '0;

  lc3_decode dut (
    .clk(clk), .rst(rst), .enable_decode(enable_decode), .flush(flush),
    .instr_in(instr_in), .npc_in(npc_in), .ir(ir), .npc_out(npc_out),
    .decode_valid(decode_valid), .alu_control(alu_control), .alu_op(alu_op),
    .imm_mode(imm_mode), .imm5_sext(imm5_sext), .offset_sext(offset_sext),
    .sr1(sr1), .sr2(sr2), .dr(dr), .reg_we(reg_we), .w_control(w_control),
    .mem_control(mem_control), .mem_indirect(mem_indirect), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Two's-complement interpretation of a bits-wide field, returned as 16 bits
  function automatic logic [15:0] sext(int v, int bits);
    int s;
    s = v;
    if (v >= (1 << (bits - 1))) s = v - (1 << bits);
    return 16'(s);
  endfunction

  function automatic dec_t ref_decode(logic [15:0] i, logic [15:0] npc);
    dec_t d;
    int   op, f_dr, f_sr1, f_lo3;
    op    = int'(i) / 4096;
    f_dr  = (int'(i) / 512) % 8;
    f_sr1 = (int'(i) / 64) % 8;
    f_lo3 = int'(i) % 8;
    d = '0;
    d.ir = i; d.npc = npc; d.valid = 1'b1;
    d.sr1  = 3'(f_sr1);
    d.imm5 = sext(int'(i) % 32, 5);
    case (op)
      1, 5: begin  // ADD, AND
        d.alu_ctl = (op == 5) ? 2'd1 : 2'd0;
        d.alu_op = 1'b1; d.imm_mode = i[5]; d.sr2 = 3'(f_lo3);
        d.dr = 3'(f_dr); d.reg_we = 1'b1;
      end
      9: begin d.alu_ctl = 2'd2; d.alu_op = 1'b1; d.dr = 3'(f_dr); d.reg_we = 1'b1; end
      2, 10, 6: begin  // LD, LDI, LDR
        d.off = (op == 6) ? sext(int'(i) % 64, 6) : sext(int'(i) % 512, 9);
        d.mem_ctl = 2'd1; d.mem_ind = (op == 10); d.dr = 3'(f_dr);
        d.reg_we = 1'b1; d.w_ctl = 2'd1;
      end
      3, 11, 7: begin  // ST, STI, STR
        d.off = (op == 7) ? sext(int'(i) % 64, 6) : sext(int'(i) % 512, 9);
        d.sr2 = 3'(f_dr); d.mem_ctl = 2'd2; d.mem_ind = (op == 11);
      end
      14: begin d.off = sext(int'(i) % 512, 9); d.dr = 3'(f_dr); d.reg_we = 1'b1; d.w_ctl = 2'd2; end
      0:  d.off = sext(int'(i) % 512, 9);
      12: ;
      4: begin
        d.off = i[11] ? sext(int'(i) % 2048, 11) : 16'h0000;
        d.dr = 3'd7; d.reg_we = 1'b1; d.w_ctl = 2'd2;
      end
      15: begin d.off = 16'(int'(i) % 256); d.dr = 3'd7; d.reg_we = 1'b1; d.w_ctl = 2'd2; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  task automatic check_all();
    chk("ir", ir, exp_s.ir);
    chk("npc_out", npc_out, exp_s.npc);
    chk("decode_valid", 16'(decode_valid), 16'(exp_s.valid));
    chk("alu_control", 16'(alu_control), 16'(exp_s.alu_ctl));
    chk("alu_op", 16'(alu_op), 16'(exp_s.alu_op));
    chk("imm_mode", 16'(imm_mode), 16'(exp_s.imm_mode));
    chk("imm5_sext", imm5_sext, exp_s.imm5);
    chk("offset_sext", offset_sext, exp_s.off);
    chk("sr1", 16'(sr1), 16'(exp_s.sr1));
    chk("sr2", 16'(sr2), 16'(exp_s.sr2));
    chk("dr", 16'(dr), 16'(exp_s.dr));
    chk("reg_we", 16'(reg_we), 16'(exp_s.reg_we));
    chk("w_control", 16'(w_control), 16'(exp_s.w_ctl));
    chk("mem_control", 16'(mem_control), 16'(exp_s.mem_ctl));
    chk("mem_indirect", 16'(mem_indirect), 16'(exp_s.mem_ind));
    chk("illegal", 16'(illegal), 16'(exp_s.illegal));
  endtask

  // Apply one cycle of inputs (called at negedge), advance the model, check after the edge
  task automatic step(input logic r, input logic en, input logic fl,
                      input logic [15:0] ins, input logic [15:0] npc);
    rst = r; enable_decode = en; flush = fl; instr_in = ins; npc_in = npc;
    @(posedge clk);
    if (r) exp_s = '0;
    else if (fl) begin
      exp_s.valid = 1'b0; exp_s.reg_we = 1'b0; exp_s.mem_ctl = 2'd0;
      exp_s.mem_ind = 1'b0; exp_s.illegal = 1'b0;
    end else if (en) exp_s = ref_decode(ins, npc);
    #1;
    check_all();
    $display("vec t=%0t rst=%0b en=%0b fl=%0b instr=%h -> ir=%h valid=%0b", $time, r, en, fl, ins, ir, decode_valid);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 16'h1261, 16'h3001);
    step(1'b1, 1'b1, 1'b0, 16'h1261, 16'h3001);
    chk("reset_valid", 16'(decode_valid), 16'h0000);
    chk("reset_ir", ir, 16'h0000);

    step(1'b0, 1'b1, 1'b0, 16'h1261, 16'h3001);
    chk("add_imm5", imm5_sext, 16'h0001);
    chk("add_dr", 16'(dr), 16'h0001);
    chk("add_imm_mode", 16'(imm_mode), 16'h0001);
    step(1'b0, 1'b1, 1'b0, 16'h5A3F, 16'h3002);
    chk("and_ctl", 16'(alu_control), 16'h0001);
    chk("and_imm5", imm5_sext, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h967F, 16'h3003);
    chk("not_ctl", 16'(alu_control), 16'h0002);
    chk("not_dr", 16'(dr), 16'h0003);
    step(1'b0, 1'b1, 1'b0, 16'hA5F0, 16'h3004);
    chk("ldi_ind", 16'(mem_indirect), 16'h0001);
    chk("ldi_off", offset_sext, 16'hFFF0);
    step(1'b0, 1'b1, 1'b0, 16'h7A7F, 16'h3005);
    chk("str_mem", 16'(mem_control), 16'h0002);
    chk("str_sr2", 16'(sr2), 16'h0005);
    chk("str_off", offset_sext, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'h4FFF, 16'h3006);
    chk("jsr_dr", 16'(dr), 16'h0007);
    chk("jsr_off", offset_sext, 16'hFFFF);
    step(1'b0, 1'b1, 1'b0, 16'hF025, 16'h3007);
    chk("trap_off", offset_sext, 16'h0025);
    step(1'b0, 1'b1, 1'b0, 16'hD000, 16'h3008);
    chk("rsvd_illegal", 16'(illegal), 16'h0001);
    chk("rsvd_valid", 16'(decode_valid), 16'h0001);
    step(1'b0, 1'b1, 1'b0, 16'h8000, 16'h3009);
    chk("rti_illegal", 16'(illegal), 16'h0001);

    step(1'b0, 1'b1, 1'b0, 16'h1261, 16'h300A);
    step(1'b0, 1'b1, 1'b1, 16'h1A85, 16'h300B);
    chk("flush_valid", 16'(decode_valid), 16'h0000);
    chk("flush_ir", ir, 16'h1261);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b0, 1'b0, 16'h5A3F, 16'h4000);
    chk("hold_ir", ir, 16'h1261);
    step(1'b0, 1'b1, 1'b0, 16'h2A10, 16'h300C);
    step(1'b1, 1'b1, 1'b1, 16'h1261, 16'h300D);
    chk("rst_wins", ir, 16'h0000);

    for (int k = 0; k < 300; k++) begin
      logic        r, en, fl;
      logic [15:0] ins;
      r   = ($urandom % 40) == 0;
      en  = ($urandom % 4) != 0;
      fl  = ($urandom % 8) == 0;
      ins = 16'($urandom);
      step(r, en, fl, ins, 16'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
